seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
Parametrised serial bit-sequence detector, the successor to the fixed 2-bit-state Mealy detector.
- Pattern, length and overlap/non-overlap mode are runtime-configurable up to PAT_W bits.
- Adds an input-valid qualifier and a registered single-cycle match pulse.
- Sits on a serial data path (UART/line decoder output) and flags framing/sync words to downstream control logic.

Parameters:
- PAT_W, 8, maximum pattern length in bits (2..32).
- DEF_PATTERN, 8'b0000_0101, pattern loaded at reset. Only bits [DEF_LEN-1:0] are significant.
- DEF_LEN, 3, pattern length loaded at reset (1..PAT_W).
- DEF_OVERLAP, 0, mode loaded at reset: 1 = overlapping, 0 = non-overlapping.
- CNT_W, 16, width of the match counter (optional feature only).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  qualifies `in`; a sample is consumed only when high.
- in  input  1  serial data bit.
- cfg_load  input  1  one-cycle strobe; latches the cfg_* inputs.
- cfg_pattern  input  PAT_W  pattern. Bit [len-1] is the first-received bit; bit [0] is the last.
- cfg_len  input  $clog2(PAT_W+1)  pattern length.
- cfg_overlap  input  1  mode select.
- match  output  1  one-cycle pulse on detection.
- busy  output  1  high while the fill count is nonzero, i.e. a partial sequence is in progress.
- match_count  output  CNT_W  saturating count of matches (optional feature only).

Behaviour:
- Reset is synchronous, active-low: on a clk edge with reset=0, all state is initialised:
  - pattern/len/overlap registers <= DEF_*
  - history <= 0, fill <= 0
  - match = 0, busy = 0, match_count = 0
- State:
  - history: PAT_W-bit shift register.
  - fill: count of valid bits accepted since the last clear, saturating at PAT_W.
  - FSM with three states:
    - IDLE: fill = 0.
    - ACCUM: 0 < fill < len.
    - ARMED: fill >= len. Compare is active.
- Accepted sample (in_valid=1, cfg_load=0):
  - history <= {history[PAT_W-2:0], in}
  - fill <= min(fill+1, PAT_W)
- Hit condition: the post-shift history[len-1:0] equals pattern[len-1:0], and the post-increment fill >= len.
- Latency: match is registered and asserts in the cycle after the clk edge that accepts the completing sample. It is high for exactly one cycle. No match without an accepted sample.
- On a hit:
  - Overlap mode: history and fill continue unchanged, so overlapping suffixes can hit again.
  - Non-overlap mode: fill <= 0 and history <= 0 at that same edge. The next match needs len fresh samples.
- Non-hit edges never clear fill; detection is a sliding window.
- in_valid=0: history, fill and FSM state hold; match=0.
- cfg_load=1:
  - Latches pattern, len and overlap; clears history and fill; match=0 next cycle.
  - A simultaneous in_valid sample is dropped.
  - cfg_load has priority over sample acceptance.
- cfg_len handling:
  - cfg_len = 0: latched as 0; the detector is disabled and never matches.
  - cfg_len > PAT_W: clamped to PAT_W.
- Pattern bits above len are ignored in the compare.
- Reset asserted mid-sequence discards partial progress. A match pending registration at that edge is suppressed, so match=0 in the next cycle.
- busy = (fill != 0), registered.

Optional Feature:
- Macro: SEQ_DET_COUNT_EN.
- Defined: match_count is present.
  - Increments by 1 in the cycle match asserts, saturating at 2^CNT_W-1.
  - Cleared by reset and by cfg_load.
- Undefined: the match_count port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset defaults (pattern 101, len 3, non-overlap), stream 1,0,1,0,1 all valid -> match after sample 3 only. Stream 1,0,1,1,0,1 -> match after samples 3 and 6.
- Load cfg_pattern=101, cfg_len=3, cfg_overlap=1; stream 1,0,1,0,1 -> match after samples 3 and 5. match_count=2 with SEQ_DET_COUNT_EN.
- Load pattern 8'b1101_0011, len 8, overlap 0; feed those 8 bits with in_valid gaps (idle cycles between bits 2,3 and 5,6) -> single match, one cycle after the 8th accepted bit. No match during gaps.
- Default config; feed 1,0 then assert reset=0 for one cycle, then feed 1 -> no match. busy=0 after reset; the sequence restarts from IDLE.
- cfg_load with cfg_len=0 -> no match on any stream. cfg_len=12 with PAT_W=8 -> behaves as len 8. cfg_load concurrent with in_valid=1 -> that bit is not counted (fill stays 0).
- SEQ_DET_COUNT_EN with CNT_W=2; pattern 1, len 1, overlap 1; feed 5 ones -> match every accepted cycle, match_count saturates at 3.

Source files
------------

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial sequence detector with valid qualifier and registered match pulse.
// Optional saturating match counter enabled by defining SEQ_DET_COUNT_EN.
module seq_detector_param #(
  parameter int unsigned      PAT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PATTERN = 8'b0000_0101,
  parameter int unsigned      DEF_LEN     = 3,
  parameter bit               DEF_OVERLAP = 1'b0
`ifdef SEQ_DET_COUNT_EN
  , parameter int unsigned    CNT_W       = 16
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       in,
  input  logic                       cfg_load,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  input  logic                       cfg_overlap,
  output logic                       match,
  output logic                       busy
`ifdef SEQ_DET_COUNT_EN
  , output logic [CNT_W-1:0]         match_count
`endif
);

  localparam int unsigned LW = $clog2(PAT_W+1);

  typedef enum logic [1:0] {IDLE, ACCUM, ARMED} state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LW-1:0]    len_q, len_d;
  logic             overlap_q, overlap_d;
  // The oldest history bit is never compared after the shift, so only PAT_W-1 bits are stored.
  logic [PAT_W-2:0] history_q, history_d;
  logic [LW-1:0]    fill_q, fill_d;
  logic             match_q, match_d;
  logic             busy_q, busy_d;
`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;
`endif

  logic [PAT_W-1:0] hist_shift;
  logic [PAT_W-1:0] len_mask;
  logic [LW-1:0]    fill_inc;
  logic [LW-1:0]    cfg_len_clamped;
  logic             hit;

  always_comb begin
    hist_shift = {history_q, in};
    fill_inc   = (fill_q == LW'(PAT_W)) ? fill_q : fill_q + LW'(1);
    len_mask   = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < 32'(len_q));
    end
    hit = (len_q != '0) && (fill_inc >= len_q) &&
          (((hist_shift ^ pattern_q) & len_mask) == '0);
    cfg_len_clamped = (cfg_len > LW'(PAT_W)) ? LW'(PAT_W) : cfg_len;

    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    history_d = history_q;
    fill_d    = fill_q;
    match_d   = 1'b0;
`ifdef SEQ_DET_COUNT_EN
    count_d   = count_q;
`endif

    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len_clamped;
      overlap_d = cfg_overlap;
      history_d = '0;
      fill_d    = '0;
`ifdef SEQ_DET_COUNT_EN
      count_d   = '0;
`endif
    end else if (in_valid) begin
      history_d = hist_shift[PAT_W-2:0];
      fill_d    = fill_inc;
      if (hit) begin
        match_d = 1'b1;
`ifdef SEQ_DET_COUNT_EN
        if (count_q != '1) count_d = count_q + CNT_W'(1);
`endif
        if (!overlap_q) begin
          history_d = '0;
          fill_d    = '0;
        end
      end
    end

    if (cfg_load || in_valid) begin
      if (fill_d == '0)         state_d = IDLE;
      else if (fill_d >= len_d) state_d = ARMED;
      else                      state_d = ACCUM;
    end

    busy_d = (fill_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      pattern_q <= DEF_PATTERN;
      len_q     <= LW'(DEF_LEN);
      overlap_q <= DEF_OVERLAP;
      history_q <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SEQ_DET_COUNT_EN
      count_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      history_q <= history_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      busy_q    <= busy_d;
`ifdef SEQ_DET_COUNT_EN
      count_q   <= count_d;
`endif
    end
  end

  assign match = match_q;
  assign busy  = busy_q;
`ifdef SEQ_DET_COUNT_EN
  assign match_count = count_q;
`endif

endmodule
